router_local_port: RTL and testbench

Packet endpoint that stands on the router side of a DMA's local port in the pkt-sim platform. It accepts packets streamed by the DMA send path into an ingress FIFO, with credit flow control and header/size/payload framing. It delivers packets pushed by the crossbar toward the DMA receive path through an egress FIFO using the tx/credit_i handshake. Both directions are independent and run concurrently.

---
 rtl/router_local_port.sv | 258 +++++++++++++++++++++++++
 tb/tb_router_local_port.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_local_port.sv
// Router-side endpoint of a DMA local port: credit-flow-controlled ingress FIFO with
// packet framing, and a first-word-fall-through egress FIFO drained by the tx/credit_i handshake.
module router_local_port #(
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDRESS    = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  rx,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  output logic                  tx,
  output logic [FLIT_WIDTH-1:0] data_o,
  input  logic                  credit_i,
  output logic [FLIT_WIDTH-1:0] in_flit_out,
  output logic                  in_tail_out,
  output logic                  in_valid_out,
  input  logic                  in_ready_in,
  input  logic [FLIT_WIDTH-1:0] out_flit_in,
  input  logic                  out_valid_in,
  output logic                  out_ready_out,
  output logic                  overflow_out,
  output logic [15:0]           pkts_in_out,
  output logic [15:0]           pkts_out_out,
  output logic [FLIT_WIDTH-1:0] addr_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      DEPTH_C        = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      CREDIT_LIMIT_C = CNT_W'(FIFO_DEPTH - 2);
  localparam logic [CNT_W-1:0]      CNT_ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0]      CNT_ZERO_C     = {CNT_W{1'b0}};
  localparam logic [PTR_W-1:0]      PTR_ONE_C      = PTR_W'(1);
  localparam logic [PTR_W-1:0]      PTR_ZERO_C     = {PTR_W{1'b0}};
  localparam logic [FLIT_WIDTH-1:0] ONE_C          = FLIT_WIDTH'(1);
  localparam logic [FLIT_WIDTH-1:0] ZERO_C         = {FLIT_WIDTH{1'b0}};
  localparam logic [FLIT_WIDTH:0]   ENTRY_ZERO_C   = {(FLIT_WIDTH+1){1'b0}};

  typedef enum logic [1:0] {
    FR_HEADER  = 2'd0,
    FR_SIZE    = 2'd1,
    FR_PAYLOAD = 2'd2
  } frame_e;

  // ---------------- ingress ----------------
  logic [FLIT_WIDTH:0]   in_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      in_wr_ptr_r;
  logic [PTR_W-1:0]      in_rd_ptr_r;
  logic [CNT_W-1:0]      in_count_r;
  logic [CNT_W-1:0]      in_count_next_s;
  logic                  in_full_s;
  logic                  in_empty_s;
  logic                  in_push_s;
  logic                  in_pop_s;
  logic                  in_drop_s;
  logic                  in_tail_s;
  frame_e                in_state_r;
  frame_e                in_state_next_s;
  logic [FLIT_WIDTH-1:0] in_remain_r;
  logic [FLIT_WIDTH-1:0] in_remain_next_s;
  logic                  credit_r;
  logic                  overflow_r;
  logic [15:0]           pkts_in_r;

  // Ingress FIFO status and handshake decode; a full FIFO still accepts a write when it pops.
  always_comb begin
    in_full_s  = (in_count_r == DEPTH_C);
    in_empty_s = (in_count_r == CNT_ZERO_C);
    in_pop_s   = ~in_empty_s & in_ready_in;
    in_push_s  = rx & (~in_full_s | in_pop_s);
    in_drop_s  = rx & ~in_push_s;
    case ({in_push_s, in_pop_s})
      2'b10:   in_count_next_s = in_count_r + CNT_ONE_C;
      2'b01:   in_count_next_s = in_count_r - CNT_ONE_C;
      default: in_count_next_s = in_count_r;
    endcase
  end

  // Ingress framing state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_state_r  <= FR_HEADER;
      in_remain_r <= ZERO_C;
    end else begin
      in_state_r  <= in_state_next_s;
      in_remain_r <= in_remain_next_s;
    end
  end

  // Ingress framing next state; every presented flit advances it, dropped or not.
  always_comb begin
    in_state_next_s  = in_state_r;
    in_remain_next_s = in_remain_r;
    if (rx) begin
      case (in_state_r)
        FR_HEADER: in_state_next_s = FR_SIZE;
        FR_SIZE: begin
          in_remain_next_s = data_i;
          in_state_next_s  = (data_i == ZERO_C) ? FR_HEADER : FR_PAYLOAD;
        end
        FR_PAYLOAD: begin
          in_remain_next_s = in_remain_r - ONE_C;
          in_state_next_s  = (in_remain_r == ONE_C) ? FR_HEADER : FR_PAYLOAD;
        end
        default: in_state_next_s = FR_HEADER;
      endcase
    end else begin
      in_state_next_s = in_state_r;
    end
  end

  // Ingress framing output: tail marker for the flit on data_i.
  always_comb begin
    case (in_state_r)
      FR_SIZE:    in_tail_s = (data_i == ZERO_C);
      FR_PAYLOAD: in_tail_s = (in_remain_r == ONE_C);
      default:    in_tail_s = 1'b0;
    endcase
  end

  // Ingress pointers, occupancy, credit, overflow flag and packet counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_wr_ptr_r <= PTR_ZERO_C;
      in_rd_ptr_r <= PTR_ZERO_C;
      in_count_r  <= CNT_ZERO_C;
      credit_r    <= 1'b0;
      overflow_r  <= 1'b0;
      pkts_in_r   <= 16'd0;
    end else begin
      if (in_push_s) in_wr_ptr_r <= in_wr_ptr_r + PTR_ONE_C;
      if (in_pop_s)  in_rd_ptr_r <= in_rd_ptr_r + PTR_ONE_C;
      in_count_r <= in_count_next_s;
      credit_r   <= (in_count_next_s <= CREDIT_LIMIT_C);
      if (in_drop_s) overflow_r <= 1'b1;
      if (in_push_s && in_tail_s) pkts_in_r <= pkts_in_r + 16'd1;
    end
  end

  // Ingress storage, tagged with the framing tail bit.
  always_ff @(posedge clock) begin
    if (!reset && in_push_s) in_mem_r[in_wr_ptr_r] <= {in_tail_s, data_i};
  end

  // ---------------- egress ----------------
  logic [FLIT_WIDTH-1:0] eg_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      eg_wr_ptr_r;
  logic [PTR_W-1:0]      eg_rd_ptr_r;
  logic [CNT_W-1:0]      eg_count_r;
  logic [CNT_W-1:0]      eg_count_next_s;
  logic                  eg_active_r;
  logic                  eg_ready_s;
  logic                  eg_empty_s;
  logic                  eg_push_s;
  logic                  eg_pop_s;
  logic [FLIT_WIDTH-1:0] eg_head_s;
  logic                  eg_tail_s;
  frame_e                eg_state_r;
  frame_e                eg_state_next_s;
  logic [FLIT_WIDTH-1:0] eg_remain_r;
  logic [FLIT_WIDTH-1:0] eg_remain_next_s;
  logic [15:0]           pkts_out_r;

  // Egress FIFO status; readiness is held low until the first cycle out of reset.
  always_comb begin
    eg_empty_s = (eg_count_r == CNT_ZERO_C);
    eg_ready_s = eg_active_r & (eg_count_r < DEPTH_C);
    eg_push_s  = out_valid_in & eg_ready_s;
    eg_pop_s   = ~eg_empty_s & credit_i;
    eg_head_s  = eg_mem_r[eg_rd_ptr_r];
    case ({eg_push_s, eg_pop_s})
      2'b10:   eg_count_next_s = eg_count_r + CNT_ONE_C;
      2'b01:   eg_count_next_s = eg_count_r - CNT_ONE_C;
      default: eg_count_next_s = eg_count_r;
    endcase
  end

  // Egress framing state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      eg_state_r  <= FR_HEADER;
      eg_remain_r <= ZERO_C;
    end else begin
      eg_state_r  <= eg_state_next_s;
      eg_remain_r <= eg_remain_next_s;
    end
  end

  // Egress framing next state, advanced by flits the DMA consumes.
  always_comb begin
    eg_state_next_s  = eg_state_r;
    eg_remain_next_s = eg_remain_r;
    if (eg_pop_s) begin
      case (eg_state_r)
        FR_HEADER: eg_state_next_s = FR_SIZE;
        FR_SIZE: begin
          eg_remain_next_s = eg_head_s;
          eg_state_next_s  = (eg_head_s == ZERO_C) ? FR_HEADER : FR_PAYLOAD;
        end
        FR_PAYLOAD: begin
          eg_remain_next_s = eg_remain_r - ONE_C;
          eg_state_next_s  = (eg_remain_r == ONE_C) ? FR_HEADER : FR_PAYLOAD;
        end
        default: eg_state_next_s = FR_HEADER;
      endcase
    end else begin
      eg_state_next_s = eg_state_r;
    end
  end

  // Egress framing output: tail marker for the head flit.
  always_comb begin
    case (eg_state_r)
      FR_SIZE:    eg_tail_s = (eg_head_s == ZERO_C);
      FR_PAYLOAD: eg_tail_s = (eg_remain_r == ONE_C);
      default:    eg_tail_s = 1'b0;
    endcase
  end

  // Egress pointers, occupancy, ready gate and delivered-packet counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      eg_wr_ptr_r <= PTR_ZERO_C;
      eg_rd_ptr_r <= PTR_ZERO_C;
      eg_count_r  <= CNT_ZERO_C;
      eg_active_r <= 1'b0;
      pkts_out_r  <= 16'd0;
    end else begin
      if (eg_push_s) eg_wr_ptr_r <= eg_wr_ptr_r + PTR_ONE_C;
      if (eg_pop_s)  eg_rd_ptr_r <= eg_rd_ptr_r + PTR_ONE_C;
      eg_count_r  <= eg_count_next_s;
      eg_active_r <= 1'b1;
      if (eg_pop_s && eg_tail_s) pkts_out_r <= pkts_out_r + 16'd1;
    end
  end

  // Egress storage.
  always_ff @(posedge clock) begin
    if (!reset && eg_push_s) eg_mem_r[eg_wr_ptr_r] <= out_flit_in;
  end

  // Output drive; an empty FIFO presents zeros.
  always_comb begin
    credit_o                   = credit_r;
    overflow_out               = overflow_r;
    pkts_in_out                = pkts_in_r;
    pkts_out_out               = pkts_out_r;
    in_valid_out               = ~in_empty_s;
    {in_tail_out, in_flit_out} = in_empty_s ? ENTRY_ZERO_C : in_mem_r[in_rd_ptr_r];
    tx                         = ~eg_empty_s;
    data_o                     = eg_empty_s ? ZERO_C : eg_head_s;
    out_ready_out              = eg_ready_s;
    addr_out                   = FLIT_WIDTH'(ADDRESS);
  end

endmodule

// File: tb/tb_router_local_port.sv
// Directed self-checking bench for router_local_port: framing, credit back-pressure,
// overflow, egress handshake, full/empty corner cases and mid-packet reset.
module tb_router_local_port;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx;
  logic [31:0] data_i;
  logic        credit_o;
  logic        tx;
  logic [31:0] data_o;
  logic        credit_i;
  logic [31:0] in_flit_out;
  logic        in_tail_out;
  logic        in_valid_out;
  logic        in_ready_in;
  logic [31:0] out_flit_in;
  logic        out_valid_in;
  logic        out_ready_out;
  logic        overflow_out;
  logic [15:0] pkts_in_out;
  logic [15:0] pkts_out_out;
  logic [31:0] addr_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] pk1 [5] = '{32'h11, 32'h3, 32'hA, 32'hB, 32'hC};
  logic [31:0] pk2 [2] = '{32'h22, 32'h0};
  logic [31:0] ovf [8] = '{32'h50, 32'h64, 32'h61, 32'h62, 32'h63, 32'h64, 32'h65, 32'h66};
  logic [31:0] eg1 [4] = '{32'h33, 32'h2, 32'h5, 32'h6};
  logic [31:0] fl  [9] = '{32'h30, 32'h0, 32'h31, 32'h0, 32'h32, 32'h0, 32'h33, 32'h0, 32'h40};
  logic [31:0] pk3 [3] = '{32'h90, 32'h1, 32'h91};

  router_local_port #(.FLIT_WIDTH(32), .FIFO_DEPTH(8), .ADDRESS(5)) dut (
    .clock(clock), .reset(reset), .rx(rx), .data_i(data_i), .credit_o(credit_o),
    .tx(tx), .data_o(data_o), .credit_i(credit_i),
    .in_flit_out(in_flit_out), .in_tail_out(in_tail_out), .in_valid_out(in_valid_out),
    .in_ready_in(in_ready_in), .out_flit_in(out_flit_in), .out_valid_in(out_valid_in),
    .out_ready_out(out_ready_out), .overflow_out(overflow_out),
    .pkts_in_out(pkts_in_out), .pkts_out_out(pkts_out_out), .addr_out(addr_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_credit"},   credit_o,      32'd0);
    check({tag, "_tx"},       tx,            32'd0);
    check({tag, "_data_o"},   data_o,        32'd0);
    check({tag, "_in_valid"}, in_valid_out,  32'd0);
    check({tag, "_in_tail"},  in_tail_out,   32'd0);
    check({tag, "_in_flit"},  in_flit_out,   32'd0);
    check({tag, "_out_rdy"},  out_ready_out, 32'd0);
    check({tag, "_ovf"},      overflow_out,  32'd0);
    check({tag, "_pkts_in"},  pkts_in_out,   32'd0);
    check({tag, "_pkts_out"}, pkts_out_out,  32'd0);
  endtask

  initial begin
    logic cred_prev;
    int   sent;
    reset = 1'b1; rx = 1'b0; data_i = 32'd0; credit_i = 1'b0;
    in_ready_in = 1'b0; out_flit_in = 32'd0; out_valid_in = 1'b0;
    tick; tick;
    check_reset_outputs("rst");
    check("addr", addr_out, 32'd5);
    reset = 1'b0;
    tick;
    check("rel_credit", credit_o, 32'd1);
    check("rel_out_rdy", out_ready_out, 32'd1);

    // Ingress packet with three payload flits, popped as they arrive.
    in_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rx = 1'b1; data_i = pk1[k];
      tick;
      check("t1_flit", in_flit_out, pk1[k]);
      check("t1_tail", in_tail_out, (k == 4) ? 32'd1 : 32'd0);
    end
    rx = 1'b0;
    check("t1_pkts", pkts_in_out, 32'd1);
    tick;
    check("t1_empty", in_valid_out, 32'd0);

    // Zero-size packet: size flit is the tail.
    for (int k = 0; k < 2; k++) begin
      rx = 1'b1; data_i = pk2[k];
      tick;
      check("t2_flit", in_flit_out, pk2[k]);
      check("t2_tail", in_tail_out, (k == 1) ? 32'd1 : 32'd0);
    end
    rx = 1'b0;
    check("t2_pkts", pkts_in_out, 32'd2);
    tick;
    check("t2_empty", in_valid_out, 32'd0);

    // Credit-obeying sender with one-cycle credit->rx latency, no pops.
    in_ready_in = 1'b0;
    cred_prev = credit_o;
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      rx = cred_prev;
      data_i = (sent < 8) ? ovf[sent] : 32'hEE;
      if (rx) sent++;
      cred_prev = credit_o;
      tick;
    end
    rx = 1'b0;
    check("cr_sent", sent, 32'd8);
    check("cr_credit_full", credit_o, 32'd0);
    check("cr_ovf_clear", overflow_out, 32'd0);
    rx = 1'b1; data_i = 32'h77;
    tick;
    rx = 1'b0;
    check("cr_ovf_set", overflow_out, 32'd1);
    in_ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("cr_drain_flit", in_flit_out, ovf[k]);
      check("cr_drain_tail", in_tail_out, 32'd0);
      tick;
    end
    in_ready_in = 1'b0;
    check("cr_dropped_gone", in_valid_out, 32'd0);
    check("cr_ovf_sticky", overflow_out, 32'd1);
    check("cr_pkts", pkts_in_out, 32'd2);

    // Egress packet; DMA consumes one cycle after seeing each flit.
    out_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      out_flit_in = eg1[k];
      tick;
      check("e1_head", data_o, 32'h33);
    end
    out_valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("e1_tx", tx, 32'd1);
      check("e1_data", data_o, eg1[k]);
      tick;
      check("e1_hold", data_o, eg1[k]);
      credit_i = 1'b1;
      tick;
      credit_i = 1'b0;
    end
    check("e1_tx_done", tx, 32'd0);
    check("e1_pkts", pkts_out_out, 32'd1);

    // credit_i on an empty egress FIFO does nothing.
    credit_i = 1'b1;
    tick; tick;
    credit_i = 1'b0;
    check("e2_tx", tx, 32'd0);
    check("e2_data", data_o, 32'd0);
    check("e2_pkts", pkts_out_out, 32'd1);

    // Fill egress, then push and consume together while full.
    out_valid_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      out_flit_in = fl[k];
      tick;
    end
    check("e3_full_rdy", out_ready_out, 32'd0);
    check("e3_head", data_o, 32'h30);
    out_flit_in = fl[8]; credit_i = 1'b1;
    tick;
    credit_i = 1'b0;
    check("e3_pop_head", data_o, 32'h0);
    tick;
    out_valid_in = 1'b0;
    check("e3_refull_rdy", out_ready_out, 32'd0);
    credit_i = 1'b1;
    for (int k = 1; k < 9; k++) begin
      check("e3_order", data_o, fl[k]);
      tick;
    end
    credit_i = 1'b0;
    check("e3_drained", tx, 32'd0);
    check("e3_pkts", pkts_out_out, 32'd5);

    // Leave both sides mid-payload, then reset.
    out_valid_in = 1'b1; out_flit_in = 32'h3;
    tick;
    out_flit_in = 32'h1;
    tick;
    out_valid_in = 1'b0; credit_i = 1'b1;
    tick; tick;
    credit_i = 1'b0; out_valid_in = 1'b1; out_flit_in = 32'h99;
    tick;
    out_valid_in = 1'b0; rx = 1'b1; data_i = 32'h88;
    tick;
    rx = 1'b0;
    check("pre_rst_in_valid", in_valid_out, 32'd1);
    check("pre_rst_tx", tx, 32'd1);
    reset = 1'b1; rx = 1'b1; in_ready_in = 1'b1; out_valid_in = 1'b1; credit_i = 1'b1;
    tick;
    check_reset_outputs("mid");
    rx = 1'b0; in_ready_in = 1'b0; out_valid_in = 1'b0; credit_i = 1'b0;
    reset = 1'b0;
    tick;
    check("mid_rel_credit", credit_o, 32'd1);
    check("mid_rel_rdy", out_ready_out, 32'd1);
    check("mid_rel_in_valid", in_valid_out, 32'd0);
    check("mid_rel_tx", tx, 32'd0);

    // Fresh packets after release are framed from HEADER.
    for (int k = 0; k < 3; k++) begin
      rx = 1'b1; data_i = pk3[k];
      tick;
    end
    rx = 1'b0;
    check("new_pkts_in", pkts_in_out, 32'd1);
    in_ready_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("new_in_flit", in_flit_out, pk3[k]);
      check("new_in_tail", in_tail_out, (k == 2) ? 32'd1 : 32'd0);
      tick;
    end
    in_ready_in = 1'b0;
    out_valid_in = 1'b1; out_flit_in = 32'hA0;
    tick;
    out_flit_in = 32'h0;
    tick;
    out_valid_in = 1'b0; credit_i = 1'b1;
    tick; tick;
    credit_i = 1'b0;
    check("new_pkts_out", pkts_out_out, 32'd1);
    check("new_tx_done", tx, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
